// File: rtl/alu_pkg.sv
// ALU operation and shifter-mode encodings shared by the execute stage,
// its shifter and the bench.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLTU  = 4'd6,
    OP_SHL   = 4'd7,
    OP_SHR   = 4'd8,
    OP_SRA   = 4'd9,
    OP_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    SFN_SHL = 2'b00,
    SFN_SHR = 2'b01,
    SFN_SRA = 2'b11
  } shift_mode_t;

  // Non-shift ops map to SHL; their shifter output is simply not selected.
  function automatic shift_mode_t op_to_sfn(alu_op_t op);
    case (op)
      OP_SHR:  return SFN_SHR;
      OP_SRA:  return SFN_SRA;
      default: return SFN_SHL;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle for the execute stage. Both the input and
// output sides use valid/ready: a transfer happens on a rising edge where
// valid && ready; the producer holds its payload stable while valid && !ready.
interface ex_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [4:0]      in_rd;
  logic            in_we;
  logic            flush;
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_zero;
  logic [4:0]      out_rd;
  logic            out_we;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_a, in_b, in_rd, in_we,
           flush, fwd_valid, fwd_rd, fwd_data, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_rd, out_we
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_a, in_b, in_rd, in_we,
           flush, fwd_valid, fwd_rd, fwd_data, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_rd, out_we
  );
endinterface

// File: rtl/ex_stage_shifter.sv
// Barrel shifter used by the execute stage: logical left/right and
// arithmetic right by a 5-bit amount.
module ex_stage_shifter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [4:0]      shamt,
  input  shift_mode_t     mode,
  output logic [XLEN-1:0] y
);

  always_comb begin
    y = '0;
    case (mode)
      SFN_SHL: y = a << shamt;
      SFN_SHR: y = a >> shamt;
      SFN_SRA: y = $signed(a) >>> shamt;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Single-cycle execute stage with a one-entry output register.
// Define EX_STAGE_FWD_EN to enable operand forwarding from EX/MEM.
module ex_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [4:0]      in_rs1,
  input  logic [4:0]      in_rs2,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [4:0]      in_rd,
  input  logic            in_we,
  input  logic            flush,
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic [4:0]      out_rd,
  output logic            out_we
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      rd_q, rd_d;
  logic            we_q, we_d;

  logic [XLEN-1:0] op_a, op_b;
  logic [XLEN-1:0] shift_y;
  logic [XLEN-1:0] alu_y;
  logic            xfer;
  alu_op_t         op;

  assign op = alu_op_t'(in_op);

`ifdef EX_STAGE_FWD_EN
  // The local EX/MEM result is younger than the MEM-stage value, so it wins.
  function automatic logic [XLEN-1:0] fwd_sel(input logic [4:0]      rs,
                                               input logic [XLEN-1:0] rf_val,
                                               input logic            lv,
                                               input logic            lwe,
                                               input logic [4:0]      lrd,
                                               input logic [XLEN-1:0] lres,
                                               input logic            fv,
                                               input logic [4:0]      frd,
                                               input logic [XLEN-1:0] fdat);
    if (lv && lwe && (lrd == rs) && (rs != 5'd0))
      return lres;
    else if (fv && (frd == rs) && (rs != 5'd0))
      return fdat;
    else
      return rf_val;
  endfunction

  always_comb begin
    op_a = fwd_sel(in_rs1, in_a, valid_q, we_q, rd_q, result_q,
                   fwd_valid, fwd_rd, fwd_data);
    op_b = fwd_sel(in_rs2, in_b, valid_q, we_q, rd_q, result_q,
                   fwd_valid, fwd_rd, fwd_data);
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_valid, fwd_rd, fwd_data, in_rs1, in_rs2};

  always_comb begin
    op_a = in_a;
    op_b = in_b;
  end
`endif

  ex_stage_shifter #(
    .XLEN (XLEN)
  ) u_shifter (
    .a     (op_a),
    .shamt (op_b[4:0]),
    .mode  (op_to_sfn(op)),
    .y     (shift_y)
  );

  always_comb begin
    alu_y = '0;
    case (op)
      OP_ADD:   alu_y = op_a + op_b;
      OP_SUB:   alu_y = op_a - op_b;
      OP_AND:   alu_y = op_a & op_b;
      OP_OR:    alu_y = op_a | op_b;
      OP_XOR:   alu_y = op_a ^ op_b;
      OP_SLT:   alu_y = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU:  alu_y = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OP_SHL,
      OP_SHR,
      OP_SRA:   alu_y = shift_y;
      OP_PASSB: alu_y = op_b;
      default:  alu_y = '0;
    endcase
  end

  assign in_ready = !valid_q || out_ready;
  assign xfer     = in_valid && in_ready;

  // Flush drops both the held result and any bundle arriving on the same edge.
  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    rd_d     = rd_q;
    we_d     = we_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (xfer) begin
      valid_d  = 1'b1;
      result_d = alu_y;
      rd_d     = in_rd;
      we_d     = in_we;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      rd_q     <= 5'd0;
      we_q     <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_zero   = (result_q == '0);
  assign out_rd     = rd_q;
  assign out_we     = we_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed scoreboard bench for ex_stage: drivers push expected results,
// a negedge monitor pops and compares on every downstream handshake.
module tb_ex_stage;
  import alu_pkg::*;

  localparam int XLEN = 32;
  localparam int W    = 38;

  logic clk;
  logic rst;

  ex_stage_if #(.XLEN(XLEN)) bus ();

  ex_stage #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (bus.in_valid),
    .in_ready   (bus.in_ready),
    .in_op      (bus.in_op),
    .in_rs1     (bus.in_rs1),
    .in_rs2     (bus.in_rs2),
    .in_a       (bus.in_a),
    .in_b       (bus.in_b),
    .in_rd      (bus.in_rd),
    .in_we      (bus.in_we),
    .flush      (bus.flush),
    .fwd_valid  (bus.fwd_valid),
    .fwd_rd     (bus.fwd_rd),
    .fwd_data   (bus.fwd_data),
    .out_valid  (bus.out_valid),
    .out_ready  (bus.out_ready),
    .out_result (bus.out_result),
    .out_zero   (bus.out_zero),
    .out_rd     (bus.out_rd),
    .out_we     (bus.out_we)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_output: got %h with empty queue", bus.out_result);
      end else begin
        e = exp_q.pop_front();
        chk("result", bus.out_result, e[37:6]);
        chk("zero", {31'b0, bus.out_zero}, {31'b0, (e[37:6] == 32'd0)});
        chk("rd", {27'b0, bus.out_rd}, {27'b0, e[5:1]});
        chk("we", {31'b0, bus.out_we}, {31'b0, e[0]});
      end
    end
  end

  // driver tasks: called at posedge+1, return at posedge+1
  task automatic send(input alu_op_t op, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic we,
                      input logic [31:0] exp_res, input bit push);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_rd    = rd;
    bus.in_we    = we;
    #1;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!bus.in_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout: in_ready got 0, expected 1");
    end else if (push) begin
      exp_q.push_back({exp_res, rd, we});
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res);
    send(op, 5'd0, 5'd0, a, b, 5'd1, 1'b1, exp_res, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'd0;
    bus.in_rs1    = 5'd0;
    bus.in_rs2    = 5'd0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_rd     = 5'd0;
    bus.in_we     = 1'b0;
    bus.flush     = 1'b0;
    bus.fwd_valid = 1'b0;
    bus.fwd_rd    = 5'd0;
    bus.fwd_data  = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    chk("rst_out_zero", {31'b0, bus.out_zero}, 32'd1);
    chk("rst_out_rd", {27'b0, bus.out_rd}, 32'd0);
    chk("rst_out_we", {31'b0, bus.out_we}, 32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // back-to-back ALU vectors with out_ready held high
    alu(OP_SHL,   32'h0000_0001, 32'd1,         32'h0000_0002);
    alu(OP_SHR,   32'hFFFF_FFF8, 32'd2,         32'h3FFF_FFFE);
    alu(OP_SRA,   32'hFFFF_FFF8, 32'd3,         32'hFFFF_FFFF);
    alu(OP_SHL,   32'hFFFF_FFF8, 32'd28,        32'h8000_0000);
    alu(OP_SHL,   32'h0000_0001, 32'h0000_0021, 32'h0000_0002);
    alu(OP_SHR,   32'h8000_0000, 32'd31,        32'h0000_0001);
    alu(OP_ADD,   32'hFFFF_FFFF, 32'd1,         32'h0000_0000);
    alu(OP_SUB,   32'h0000_0000, 32'd1,         32'hFFFF_FFFF);
    alu(OP_AND,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    alu(OP_OR,    32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0);
    alu(OP_XOR,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
    alu(OP_SLT,   32'hFFFF_FFFF, 32'd1,         32'h0000_0001);
    alu(OP_SLTU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000);
    alu(OP_PASSB, 32'hDEAD_0000, 32'h0000_1234, 32'h0000_1234);
    send(alu_op_t'(4'hF), 5'd0, 5'd0, 32'h1234_5678, 32'h1, 5'd9, 1'b0, 32'd0, 1'b1);
    idle(2);
    chk("b2b_queue_drained", exp_q.size(), 32'd0);

    // stall: SUB 5-5 held for 3 cycles
    bus.out_ready = 1'b0;
    send(OP_SUB, 5'd0, 5'd0, 32'd5, 32'd5, 5'd3, 1'b1, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("stall_result", bus.out_result, 32'd0);
      chk("stall_zero", {31'b0, bus.out_zero}, 32'd1);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release_valid", {31'b0, bus.out_valid}, 32'd0);

    // flush while stalled with a new bundle offered
    bus.out_ready = 1'b0;
    send(OP_ADD, 5'd0, 5'd0, 32'd1, 32'd2, 5'd4, 1'b1, 32'd3, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_op    = OP_ADD;
    bus.in_a     = 32'd4;
    bus.in_b     = 32'd4;
    bus.flush    = 1'b1;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_stalled_valid", {31'b0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;
    idle(2);

    // flush on an empty stage with an accepted-looking transfer
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk);
    #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_empty_valid", {31'b0, bus.out_valid}, 32'd0);

    // reset aborts a stalled result
    bus.out_ready = 1'b0;
    send(OP_ADD, 5'd0, 5'd0, 32'd10, 32'd20, 5'd7, 1'b1, 32'd30, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_abort_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_abort_result", bus.out_result, 32'd0);
    chk("rst_abort_zero", {31'b0, bus.out_zero}, 32'd1);
    bus.out_ready = 1'b1;
    idle(2);

    // MEM forward on a matching nonzero register
    bus.fwd_valid = 1'b1;
    bus.fwd_rd    = 5'd1;
    bus.fwd_data  = 32'h55;
`ifdef EX_STAGE_FWD_EN
    send(OP_ADD, 5'd1, 5'd1, 32'd2, 32'd3, 5'd8, 1'b1, 32'h0000_00AA, 1'b1);
`else
    send(OP_ADD, 5'd1, 5'd1, 32'd2, 32'd3, 5'd8, 1'b1, 32'h0000_0005, 1'b1);
`endif
    bus.fwd_valid = 1'b0;
    idle(2);

`ifdef EX_STAGE_FWD_EN
    // EX/MEM forward: x5 = 7, then x6 = x5 + x5 with zeroed rf operands
    send(OP_ADD, 5'd0, 5'd0, 32'd3, 32'd4, 5'd5, 1'b1, 32'd7, 1'b1);
    send(OP_ADD, 5'd5, 5'd5, 32'd0, 32'd0, 5'd6, 1'b1, 32'd14, 1'b1);
    idle(2);
    // x0 is never forwarded
    bus.fwd_valid = 1'b1;
    bus.fwd_rd    = 5'd0;
    bus.fwd_data  = 32'h55;
    send(OP_ADD, 5'd0, 5'd0, 32'd1, 32'd2, 5'd9, 1'b1, 32'd3, 1'b1);
    bus.fwd_valid = 1'b0;
    idle(2);
`endif

    idle(3);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
